// File: rtl/cbc_stream_decryptor_4bit_if.sv
// cbc_stream_decryptor_4bit_if: control, ciphertext-in and plaintext-out stream bundle
interface cbc_stream_decryptor_4bit_if #(
    parameter int CNT_W = 8
) ();
    logic             key_load;
    logic [3:0]       key_in;
    logic [3:0]       iv_in;
    logic             s_valid;
    logic             s_ready;
    logic [3:0]       s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [3:0]       m_data;
    logic             m_last;
    logic             busy;
    logic [CNT_W-1:0] blk_count;

    modport master (
        output key_load, key_in, iv_in, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, busy, blk_count
    );

    modport slave (
        input  key_load, key_in, iv_in, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, busy, blk_count
    );
endinterface

// File: rtl/cbc_stream_decryptor_4bit.sv
// cbc_stream_decryptor_4bit: streaming nibble decryptor, p = swap(c) ^ key ^ chain (CBC or ECB)
module cbc_stream_decryptor_4bit #(
    parameter bit CBC_EN = 1'b1,
    parameter int CNT_W  = 8
) (
    input logic                        clk,
    input logic                        reset,
    cbc_stream_decryptor_4bit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [3:0]       key_q, key_d, chain_q, chain_d, m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_ready, busy, accept, m_hs, last_out;
    logic [3:0]       chain_term, plain;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.key_load ? ACTIVE : IDLE;
            ACTIVE:  state_d = (accept && bus.s_last) ? DRAIN : ACTIVE;
            DRAIN:   state_d = last_out ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // single-entry output register: accept whenever it is empty or draining this cycle
    always_comb begin
        s_ready = (state_q == ACTIVE) && (!m_valid_q || bus.m_ready);
        busy    = (state_q != IDLE);
    end

    assign accept     = bus.s_valid && s_ready;
    assign m_hs       = m_valid_q && bus.m_ready;
    assign last_out   = (state_q == DRAIN) && m_hs && m_last_q;
    assign chain_term = CBC_EN ? chain_q : 4'h0;
    assign plain      = {bus.s_data[2], bus.s_data[3], bus.s_data[0], bus.s_data[1]} ^ key_q ^ chain_term;

    always_comb begin
        key_d     = key_q;
        chain_d   = chain_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_valid_d = m_hs ? 1'b0 : m_valid_q;
        if (state_q == IDLE && bus.key_load) begin
            key_d   = bus.key_in;
            chain_d = bus.iv_in;
            cnt_d   = '0;
        end
        if (accept) begin
            m_data_d  = plain;
            m_last_d  = bus.s_last;
            m_valid_d = 1'b1;
            chain_d   = bus.s_data;
            cnt_d     = cnt_q + CNT_W'(1);
        end
        if (last_out) chain_d = 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q     <= 4'h0;
            chain_q   <= 4'h0;
            cnt_q     <= '0;
            m_data_q  <= 4'h0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            chain_q   <= chain_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.busy      = busy;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_last    = m_last_q;
    assign bus.blk_count = cnt_q;
endmodule

// File: tb/tb_cbc_stream_decryptor_4bit.sv
// tb_cbc_stream_decryptor_4bit: directed scenarios across CBC, ECB and narrow-counter instances
module tb_cbc_stream_decryptor_4bit;
    logic clk, reset;
    int   checks, failures;

    cbc_stream_decryptor_4bit_if #(.CNT_W(8)) a ();
    cbc_stream_decryptor_4bit_if #(.CNT_W(8)) e ();
    cbc_stream_decryptor_4bit_if #(.CNT_W(2)) w ();

    cbc_stream_decryptor_4bit #(.CBC_EN(1'b1), .CNT_W(8)) dut     (.clk(clk), .reset(reset), .bus(a.slave));
    cbc_stream_decryptor_4bit #(.CBC_EN(1'b0), .CNT_W(8)) dut_ecb (.clk(clk), .reset(reset), .bus(e.slave));
    cbc_stream_decryptor_4bit #(.CBC_EN(1'b1), .CNT_W(2)) dut_w2  (.clk(clk), .reset(reset), .bus(w.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (a.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", a.m_valid); end
        checks++; if (a.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", a.s_ready); end
        checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a.busy); end
        checks++; if (a.blk_count !== 8'd0) begin failures++; $display("FAIL reset_blk_count got=%0d exp=0", a.blk_count); end
        checks++; if (a.m_data !== 4'h0 || a.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_data got=%h/%b exp=0/0", a.m_data, a.m_last); end
    endtask

    task automatic test_cbc_basic();
        a.key_load = 1'b1; a.key_in = 4'h3; a.iv_in = 4'h0;
        step();
        a.key_load = 1'b0;
        checks++; if (a.busy !== 1'b1 || a.s_ready !== 1'b1) begin failures++; $display("FAIL cbc_armed busy/s_ready got=%b/%b exp=1/1", a.busy, a.s_ready); end
        a.m_ready = 1'b1; a.s_valid = 1'b1; a.s_data = 4'hA; a.s_last = 1'b0;
        step();
        checks++; if (a.m_valid !== 1'b1 || a.m_data !== 4'h6 || a.m_last !== 1'b0) begin failures++; $display("FAIL cbc_first got=%b/%h/%b exp=1/6/0", a.m_valid, a.m_data, a.m_last); end
        a.s_data = 4'h5; a.s_last = 1'b1;
        step();
        a.s_valid = 1'b0; a.s_last = 1'b0;
        checks++; if (a.m_valid !== 1'b1 || a.m_data !== 4'h3 || a.m_last !== 1'b1) begin failures++; $display("FAIL cbc_second got=%b/%h/%b exp=1/3/1", a.m_valid, a.m_data, a.m_last); end
        checks++; if (a.busy !== 1'b1 || a.s_ready !== 1'b0) begin failures++; $display("FAIL cbc_drain busy/s_ready got=%b/%b exp=1/0", a.busy, a.s_ready); end
        step();
        checks++; if (a.m_valid !== 1'b0 || a.busy !== 1'b0) begin failures++; $display("FAIL cbc_idle m_valid/busy got=%b/%b exp=0/0", a.m_valid, a.busy); end
        checks++; if (a.blk_count !== 8'd2) begin failures++; $display("FAIL cbc_count got=%0d exp=2", a.blk_count); end
    endtask

    task automatic test_backpressure();
        a.key_load = 1'b1; a.key_in = 4'h3; a.iv_in = 4'h0;
        step();
        a.key_load = 1'b0;
        a.m_ready = 1'b0; a.s_valid = 1'b1; a.s_data = 4'hA; a.s_last = 1'b0;
        step();
        a.s_data = 4'h5; a.s_last = 1'b1;
        checks++; if (a.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready got=%b exp=0", a.s_ready); end
        step();
        checks++; if (a.m_valid !== 1'b1 || a.m_data !== 4'h6 || a.blk_count !== 8'd1) begin failures++; $display("FAIL bp_hold1 got=%b/%h/%0d exp=1/6/1", a.m_valid, a.m_data, a.blk_count); end
        step();
        checks++; if (a.m_data !== 4'h6 || a.m_last !== 1'b0 || a.blk_count !== 8'd1) begin failures++; $display("FAIL bp_hold2 got=%h/%b/%0d exp=6/0/1", a.m_data, a.m_last, a.blk_count); end
        a.m_ready = 1'b1;
        #1;
        checks++; if (a.s_ready !== 1'b1) begin failures++; $display("FAIL bp_release_s_ready got=%b exp=1", a.s_ready); end
        step();
        a.s_valid = 1'b0; a.s_last = 1'b0;
        checks++; if (a.m_valid !== 1'b1 || a.m_data !== 4'h3 || a.m_last !== 1'b1 || a.blk_count !== 8'd2) begin failures++; $display("FAIL bp_second got=%b/%h/%b/%0d exp=1/3/1/2", a.m_valid, a.m_data, a.m_last, a.blk_count); end
        step();
        checks++; if (a.m_valid !== 1'b0 || a.busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b/%b exp=0/0", a.m_valid, a.busy); end
    endtask

    task automatic test_key_load_ignored();
        a.key_load = 1'b1; a.key_in = 4'h3; a.iv_in = 4'h0;
        step();
        a.key_in = 4'hF; a.iv_in = 4'hF;
        a.m_ready = 1'b1; a.s_valid = 1'b1; a.s_data = 4'hA; a.s_last = 1'b0;
        step();
        checks++; if (a.m_data !== 4'h6 || a.blk_count !== 8'd1) begin failures++; $display("FAIL kl_first got=%h/%0d exp=6/1", a.m_data, a.blk_count); end
        a.s_data = 4'h5; a.s_last = 1'b1;
        step();
        a.key_load = 1'b0; a.s_valid = 1'b0; a.s_last = 1'b0;
        checks++; if (a.m_data !== 4'h3 || a.blk_count !== 8'd2) begin failures++; $display("FAIL kl_second got=%h/%0d exp=3/2", a.m_data, a.blk_count); end
        step();
        checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL kl_idle busy got=%b exp=0", a.busy); end
    endtask

    task automatic test_reset_mid();
        a.key_load = 1'b1; a.key_in = 4'h3; a.iv_in = 4'h0;
        step();
        a.key_load = 1'b0;
        a.m_ready = 1'b0; a.s_valid = 1'b1; a.s_data = 4'hA;
        step();
        a.s_valid = 1'b0;
        checks++; if (a.m_valid !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%b exp=1", a.m_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (a.m_valid !== 1'b0 || a.busy !== 1'b0 || a.blk_count !== 8'd0 || a.m_data !== 4'h0) begin failures++; $display("FAIL rmid_cleared got=%b/%b/%0d/%h exp=0/0/0/0", a.m_valid, a.busy, a.blk_count, a.m_data); end
        a.m_ready = 1'b1;
    endtask

    task automatic test_idle_reject();
        a.s_valid = 1'b1; a.s_data = 4'h9; a.s_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (a.s_ready !== 1'b0) begin failures++; $display("FAIL idle_s_ready cyc=%0d got=%b exp=0", i, a.s_ready); end
            step();
        end
        a.s_valid = 1'b0; a.s_last = 1'b0;
        checks++; if (a.m_valid !== 1'b0 || a.blk_count !== 8'd0) begin failures++; $display("FAIL idle_no_accept got=%b/%0d exp=0/0", a.m_valid, a.blk_count); end
    endtask

    task automatic test_ecb();
        e.key_load = 1'b1; e.key_in = 4'h3; e.iv_in = 4'h5;
        step();
        e.key_load = 1'b0;
        e.m_ready = 1'b1; e.s_valid = 1'b1; e.s_data = 4'hA; e.s_last = 1'b0;
        step();
        checks++; if (e.m_data !== 4'h6) begin failures++; $display("FAIL ecb_first got=%h exp=6", e.m_data); end
        e.s_last = 1'b1;
        step();
        e.s_valid = 1'b0; e.s_last = 1'b0;
        checks++; if (e.m_data !== 4'h6 || e.m_last !== 1'b1) begin failures++; $display("FAIL ecb_second got=%h/%b exp=6/1", e.m_data, e.m_last); end
        step();
        checks++; if (e.blk_count !== 8'd2 || e.busy !== 1'b0) begin failures++; $display("FAIL ecb_count got=%0d/%b exp=2/0", e.blk_count, e.busy); end
    endtask

    task automatic test_back_to_back_wrap();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        w.key_load = 1'b1; w.key_in = 4'h3; w.iv_in = 4'h0;
        step();
        w.key_load = 1'b0;
        w.m_ready = 1'b1; w.s_valid = 1'b1; w.s_data = 4'h0; w.s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w.s_last = (i == 4);
            step();
            checks++; if (w.m_valid !== 1'b1 || w.m_data !== 4'h3 || w.blk_count !== exp_cnt[i]) begin failures++; $display("FAIL b2b_wrap i=%0d got=%b/%h/%0d exp=1/3/%0d", i, w.m_valid, w.m_data, w.blk_count, exp_cnt[i]); end
        end
        w.s_valid = 1'b0; w.s_last = 1'b0;
        step();
        checks++; if (w.blk_count !== 2'd1 || w.busy !== 1'b0 || w.m_valid !== 1'b0) begin failures++; $display("FAIL wrap_final got=%0d/%b/%b exp=1/0/0", w.blk_count, w.busy, w.m_valid); end
    endtask

    initial begin
        checks = 0; failures = 0; reset = 1'b1;
        a.key_load = 1'b0; a.key_in = 4'h0; a.iv_in = 4'h0; a.s_valid = 1'b0; a.s_data = 4'h0; a.s_last = 1'b0; a.m_ready = 1'b0;
        e.key_load = 1'b0; e.key_in = 4'h0; e.iv_in = 4'h0; e.s_valid = 1'b0; e.s_data = 4'h0; e.s_last = 1'b0; e.m_ready = 1'b0;
        w.key_load = 1'b0; w.key_in = 4'h0; w.iv_in = 4'h0; w.s_valid = 1'b0; w.s_data = 4'h0; w.s_last = 1'b0; w.m_ready = 1'b0;
        test_reset();
        test_cbc_basic();
        test_backpressure();
        test_key_load_ignored();
        test_reset_mid();
        test_idle_reject();
        test_ecb();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
